gate_alu_pipe: RTL
==================

Name: gate_alu_pipe

Overview:
- Parametrised, pipelined bitwise logic unit, successor to the team's single-bit combinational gate block.
- Takes WIDTH-bit operands and an op select, and returns one selected bitwise result plus zero and parity flags.
- Supports an accumulate mode that folds each accepted operand into a running register.
- Sits between producer and consumer on valid/ready streams, with full backpressure support.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..64.
- STAGES, 2, number of register stages from input acceptance to output; legal range 1..4.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  producer has an operand beat.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored in accumulate mode.
- op  input  3  operation select, encodings below.
- acc_en  input  1  accumulate mode: operand B is replaced by the accumulator.
- acc_clr  input  1  with acc_en, loads the accumulator from a, ignoring op.
- out_valid  output  1  result beat available.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result.
- zero  output  1  y is all zeros.
- parity  output  1  XOR-reduction of y.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- Op encodings:
  - 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT (~a; b ignored).
  - 7 PASS (a; b ignored).
  - All ops are bitwise across WIDTH.
- Acceptance: a beat is accepted when in_valid && in_ready on a rising edge. a, b, op, acc_en and acc_clr are sampled only at acceptance.
- Result computation at acceptance:
  - acc_en=0: r = op(a, b).
  - acc_en=1, acc_clr=0: r = op(acc, a), and acc <= r.
  - acc_en=1, acc_clr=1: r = a, and acc <= a.
  - acc_clr with acc_en=0 is ignored.
  - acc changes only on an accepted beat with acc_en=1.
- Pipeline structure:
  - STAGES registers, each holding {valid, data}. Stage 1 captures r.
  - Stage k advances into stage k+1 when stage k+1 is empty or itself advancing.
  - The last stage drives y and out_valid and is released when out_ready=1.
- Flags: zero and parity are registered alongside y in the last stage (computed from r at stage-1 capture and carried down the pipe). They always describe the current y.
- Ready and throughput:
  - in_ready = !stage1.valid || stage1 advancing.
  - in_ready is combinationally dependent on out_ready through the stage chain; this path is permitted.
  - Throughput is 1 beat/cycle with out_ready held high.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES cycles from in_valid sample to out_valid, when there is no stall.
- Stall behaviour:
  - While out_valid=1 and out_ready=0, y, zero and parity hold stable.
  - No beat is dropped or duplicated.
  - Order is preserved.
- Full pipeline: with all STAGES valid and out_ready=0, in_ready=0. An in_valid beat is held off and not consumed.
- Simultaneous release and accept: when the last stage is released and a new beat is accepted on the same edge, both occur. Occupancy is unchanged.
- Reset values:
  - All stage valid bits 0, all stage data 0, acc 0.
  - out_valid=0, y=0, zero=1, parity=0.
  - in_ready=1 after the reset edge.
- Reset mid-operation: all in-flight beats are discarded and acc is cleared on the reset edge. in_ready is 0 while rst_n=0.
- Width rules:
  - No arithmetic and no carries.
  - The accumulator is exactly WIDTH bits.
  - The op field is fully decoded, with no illegal codes.

Decomposition:
- Package gate_alu_pkg holds:
  - Op encoding constants (OP_AND..OP_PASS) and an op_t 3-bit typedef.
  - A pure function computing bitwise op(x, y), shared by RTL and the bench reference model.
- Sub-module gate_alu_stage: one valid/data register slice with pass-through ready logic.
  - Instantiated STAGES times via generate.
  - Data width is WIDTH+2, carrying the zero and parity flags.

Test Plan:
- Reset and idle: hold rst_n=0 for 2 cycles, then release → out_valid=0, y=0, zero=1, parity=0, in_ready=1.
- Op sweep: WIDTH=8, STAGES=2, a=0xA5, b=0x3C, ops 0..7 back to back with out_ready=1 → y=0x24, 0xBD, 0xDB, 0x42, 0x99, 0x66, 0x5A, 0xA5 in order. Each appears 2 cycles after its input, one per cycle. Parity of 0x24 is 0.
- Backpressure: stream 6 XOR beats, hold out_ready=0 for 5 cycles → in_ready falls after STAGES beats are accepted and y stays stable. On release, all 6 results arrive in order with none lost.
- Accumulate: acc_en=1, first beat acc_clr=1 with a=0xF0, then XOR beats a=0x0F and a=0xFF → outputs 0xF0, 0xFF, 0x00, with zero=1 on the last.
- Accumulate ignored: acc_clr=1 with acc_en=0, op=AND, a=0x12, b=0x10 → y=0x10 and acc is unchanged, as checked by a subsequent accumulate beat.
- Mid-stream reset: assert rst_n=0 with 2 beats in flight and acc=0x55 → out_valid=0 next cycle and no stale beat emerges. After release, an acc_en XOR beat with a=0x01 yields 0x01.

Source files
------------

// File: rtl/gate_alu_pkg.sv
// rtl/gate_alu_pkg.sv - op encodings and shared bitwise op function for gate_alu_pipe
package gate_alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_NAND = 3'd2;
  localparam op_t OP_NOR  = 3'd3;
  localparam op_t OP_XOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOT  = 3'd6;
  localparam op_t OP_PASS = 3'd7;

  localparam int MAX_WIDTH = 64;

  // Evaluated at the widest legal width; callers truncate to their own WIDTH.
  function automatic logic [MAX_WIDTH-1:0] gate_op(
    input op_t                  op,
    input logic [MAX_WIDTH-1:0] x,
    input logic [MAX_WIDTH-1:0] y
  );
    logic [MAX_WIDTH-1:0] res;
    case (op)
      OP_AND:  res = x & y;
      OP_OR:   res = x | y;
      OP_NAND: res = ~(x & y);
      OP_NOR:  res = ~(x | y);
      OP_XOR:  res = x ^ y;
      OP_XNOR: res = ~(x ^ y);
      OP_NOT:  res = ~x;
      default: res = x;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/gate_alu_stage.sv
// rtl/gate_alu_stage.sv - one valid/data register slice with pass-through ready
module gate_alu_stage #(
  parameter int DW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // Accept when empty or when the held beat leaves on this same edge.
  always_comb begin
    in_ready = !valid_q || out_ready;
    valid_d  = in_ready ? in_valid : valid_q;
    data_d   = (in_valid && in_ready) ? in_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/gate_alu_pipe.sv
// rtl/gate_alu_pipe.sv - pipelined bitwise logic unit with accumulator and valid/ready streams
module gate_alu_pipe
  import gate_alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);

  // Slice payload is {parity, nonzero, result}; storing nonzero lets a cleared
  // slice read back as y=0 with zero=1.
  localparam int DW = WIDTH + 2;

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] x_sel, y_sel, op_res, r;
  logic             accept;

  logic [STAGES:0]  vld;
  logic [STAGES:0]  rdy;
  logic [DW-1:0]    dat [STAGES+1];

  always_comb begin
    accept = in_valid && in_ready;
    x_sel  = acc_en ? acc_q : a;
    y_sel  = acc_en ? a : b;
    op_res = WIDTH'(gate_op(op_t'(op), MAX_WIDTH'(x_sel), MAX_WIDTH'(y_sel)));
    r      = (acc_en && acc_clr) ? a : op_res;
    acc_d  = (accept && acc_en) ? r : acc_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign vld[0]      = in_valid;
  assign dat[0]      = {^r, |r, r};
  assign rdy[STAGES] = out_ready;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    gate_alu_stage #(.DW(DW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[i]),
      .in_data   (dat[i]),
      .in_ready  (rdy[i]),
      .out_valid (vld[i+1]),
      .out_data  (dat[i+1]),
      .out_ready (rdy[i+1])
    );
  end

  assign in_ready  = rst_n && rdy[0];
  assign out_valid = vld[STAGES];
  assign y         = dat[STAGES][WIDTH-1:0];
  assign zero      = ~dat[STAGES][WIDTH];
  assign parity    = dat[STAGES][WIDTH+1];

endmodule
